// File: rtl/advanced_riscv_pipeline.sv
// advanced_riscv_pipeline: five-stage (IF/ID/EX/MEM/WB) in-order RV32I-subset core
// with on-chip instruction and data memories.
//
// Ports:
//   clk  - single clock, all state updates on the rising edge
//   rst  - asynchronous active-low reset; clears pc, pipeline, register file
//          and data memory (instruction memory is retained)
//
// Parameters:
//   IMEM_DEPTH - instruction memory words (power of two, addresses wrap)
//   DMEM_DEPTH - data memory words (power of two, addresses wrap)
//   IMEM_INIT  - name of the program image; the image is placed into imem by
//                the environment (ROM preload or hierarchical load)
//
// Architectural state (pc, rf, dmem) is observed hierarchically.
module advanced_riscv_pipeline #(
  parameter int    IMEM_DEPTH = 64,
  parameter int    DMEM_DEPTH = 64,
  parameter string IMEM_INIT  = "program.hex"
) (
  input logic clk,
  input logic rst
);

  localparam int IA = $clog2(IMEM_DEPTH);
  localparam int DA = $clog2(DMEM_DEPTH);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL
  } alu_op_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } ifid_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1v;
    logic [31:0] rs2v;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    alu_op_t     alu;
    logic        alu_imm;
    logic        reg_wr;
    logic        mem_rd;
    logic        mem_wr;
    logic        br_eq;
    logic        br_ne;
    logic        jal;
  } idex_t;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic        reg_wr;
    logic        mem_rd;
    logic        mem_wr;
  } exmem_t;

  typedef struct packed {
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        reg_wr;
  } memwb_t;

  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] dmem [DMEM_DEPTH];
  logic [31:0] rf   [32];

  logic [31:0] pc;
  ifid_t       ifid;
  idex_t       idex, dec;
  exmem_t      exmem, ex_nxt;
  memwb_t      memwb, wb_nxt;

  // ---------------- ID: decode ----------------
  logic [31:0] ir, imm_i, imm_s, imm_b, imm_j;
  logic        ok;
  alu_op_t     op;
  logic        stall;

  assign ir    = ifid.ir;
  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  always_comb begin
    dec    = '0;
    ok     = 1'b0;
    op     = ALU_ADD;
    dec.pc = ifid.pc;
    case (ir[6:0])
      OP_R: begin
        ok = (ir[31:25] == 7'h00 || (ir[31:25] == 7'h20 && ir[14:12] == 3'b000))
             && ir[14:12] != 3'b011;
        case (ir[14:12])
          3'b000:  op = ir[30] ? ALU_SUB : ALU_ADD;
          3'b001:  op = ALU_SLL;
          3'b010:  op = ALU_SLT;
          3'b100:  op = ALU_XOR;
          3'b101:  op = ALU_SRL;
          3'b110:  op = ALU_OR;
          default: op = ALU_AND;
        endcase
        if (ok) begin
          dec.alu    = op;
          dec.reg_wr = 1'b1;
          dec.rd     = ir[11:7];
          dec.rs1    = ir[19:15];
          dec.rs2    = ir[24:20];
        end
      end
      OP_I: begin
        ok = 1'b1;
        case (ir[14:12])
          3'b000:  op = ALU_ADD;
          3'b010:  op = ALU_SLT;
          3'b100:  op = ALU_XOR;
          3'b110:  op = ALU_OR;
          3'b111:  op = ALU_AND;
          default: ok = 1'b0;
        endcase
        if (ok) begin
          dec.alu     = op;
          dec.alu_imm = 1'b1;
          dec.imm     = imm_i;
          dec.reg_wr  = 1'b1;
          dec.rd      = ir[11:7];
          dec.rs1     = ir[19:15];
        end
      end
      OP_LW: if (ir[14:12] == 3'b010) begin
        dec.alu_imm = 1'b1;
        dec.imm     = imm_i;
        dec.reg_wr  = 1'b1;
        dec.mem_rd  = 1'b1;
        dec.rd      = ir[11:7];
        dec.rs1     = ir[19:15];
      end
      OP_SW: if (ir[14:12] == 3'b010) begin
        dec.alu_imm = 1'b1;
        dec.imm     = imm_s;
        dec.mem_wr  = 1'b1;
        dec.rs1     = ir[19:15];
        dec.rs2     = ir[24:20];
      end
      OP_BR: if (ir[14:13] == 2'b00) begin
        dec.imm   = imm_b;
        dec.br_eq = ~ir[12];
        dec.br_ne = ir[12];
        dec.rs1   = ir[19:15];
        dec.rs2   = ir[24:20];
      end
      OP_JAL: begin
        dec.imm    = imm_j;
        dec.jal    = 1'b1;
        dec.reg_wr = 1'b1;
        dec.rd     = ir[11:7];
      end
      default: ;
    endcase
    // write-through: WB result this cycle is visible to the ID read
    dec.rs1v = (memwb.reg_wr && memwb.rd != 5'd0 && memwb.rd == dec.rs1) ? memwb.wdata : rf[dec.rs1];
    dec.rs2v = (memwb.reg_wr && memwb.rd != 5'd0 && memwb.rd == dec.rs2) ? memwb.wdata : rf[dec.rs2];
  end

  // unused source fields decode to x0, so they never match a nonzero load rd
  assign stall = idex.mem_rd && idex.rd != 5'd0 && (idex.rd == dec.rs1 || idex.rd == dec.rs2);

  // ---------------- EX ----------------
  logic [31:0] fa, fb, alu_b, alu_y, target;
  logic        take;

  assign fa = (exmem.reg_wr && exmem.rd != 5'd0 && exmem.rd == idex.rs1) ? exmem.result :
              (memwb.reg_wr && memwb.rd != 5'd0 && memwb.rd == idex.rs1) ? memwb.wdata  : idex.rs1v;
  assign fb = (exmem.reg_wr && exmem.rd != 5'd0 && exmem.rd == idex.rs2) ? exmem.result :
              (memwb.reg_wr && memwb.rd != 5'd0 && memwb.rd == idex.rs2) ? memwb.wdata  : idex.rs2v;
  assign alu_b  = idex.alu_imm ? idex.imm : fb;
  assign target = idex.pc + idex.imm;
  assign take   = (idex.br_eq && fa == fb) || (idex.br_ne && fa != fb) || idex.jal;

  always_comb begin
    case (idex.alu)
      ALU_ADD: alu_y = fa + alu_b;
      ALU_SUB: alu_y = fa - alu_b;
      ALU_AND: alu_y = fa & alu_b;
      ALU_OR:  alu_y = fa | alu_b;
      ALU_XOR: alu_y = fa ^ alu_b;
      ALU_SLT: alu_y = {31'b0, $signed(fa) < $signed(alu_b)};
      ALU_SLL: alu_y = fa << alu_b[4:0];
      ALU_SRL: alu_y = fa >> alu_b[4:0];
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    ex_nxt        = '0;
    ex_nxt.result = idex.jal ? idex.pc + 32'd4 : alu_y;
    ex_nxt.sdata  = fb;
    ex_nxt.rd     = idex.rd;
    ex_nxt.reg_wr = idex.reg_wr;
    ex_nxt.mem_rd = idex.mem_rd;
    ex_nxt.mem_wr = idex.mem_wr;
  end

  // ---------------- MEM ----------------
  always_comb begin
    wb_nxt        = '0;
    wb_nxt.wdata  = exmem.mem_rd ? dmem[exmem.result[DA+1:2]] : exmem.result;
    wb_nxt.rd     = exmem.rd;
    wb_nxt.reg_wr = exmem.reg_wr;
  end

  // ---------------- state ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc    <= '0;
      ifid  <= '0;
      idex  <= '0;
      exmem <= '0;
      memwb <= '0;
    end else begin
      exmem <= ex_nxt;
      memwb <= wb_nxt;
      if (take) begin
        pc   <= target;
        ifid <= '0;
        idex <= '0;
      end else if (stall) begin
        idex <= '0;
      end else begin
        pc      <= pc + 32'd4;
        ifid.pc <= pc;
        ifid.ir <= imem[pc[IA+1:2]];
        idex    <= dec;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (memwb.reg_wr && memwb.rd != 5'd0) begin
      rf[memwb.rd] <= memwb.wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= '0;
    end else if (exmem.mem_wr) begin
      dmem[exmem.result[DA+1:2]] <= exmem.sdata;
    end
  end

endmodule

// File: tb/tb_advanced_riscv_pipeline.sv
// Bench for advanced_riscv_pipeline: directed programs with timing checks plus
// random programs compared against an instruction-level reference model.
module tb_advanced_riscv_pipeline;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  advanced_riscv_pipeline #(.IMEM_DEPTH(64), .DMEM_DEPTH(64)) dut (.clk(clk), .rst(rst));

  localparam logic [31:0] HALT = 32'h0000006f; // jal x0,0
  localparam logic [31:0] NOP  = 32'h00000013; // addi x0,x0,0

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] img  [64];
  int          plen;
  logic [31:0] m_rf [32];
  logic [31:0] m_dm [64];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- encoders ----------------
  function automatic logic [31:0] e_r(input logic [6:0] f7, input logic [2:0] f3, input int rd, input int rs1, input int rs2);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] e_i(input logic [2:0] f3, input int rd, input int rs1, input int imm, input logic [6:0] op);
    return {12'(imm), 5'(rs1), f3, 5'(rd), op};
  endfunction
  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return e_i(3'b000, rd, rs1, imm, 7'b0010011);
  endfunction
  function automatic logic [31:0] e_s(input int rs2, input int rs1, input int imm);
    logic [11:0] v;
    v = 12'(imm);
    return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] e_b(input logic [2:0] f3, input int rs1, input int rs2, input int imm);
    logic [12:0] v;
    v = 13'(imm);
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), f3, v[4:1], v[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] e_j(input int rd, input int imm);
    logic [20:0] v;
    v = 21'(imm);
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'b1101111};
  endfunction

  task automatic clear();
    plen = 0;
    for (int i = 0; i < 64; i++) img[i] = HALT;
  endtask
  task automatic put(input logic [31:0] w);
    img[plen] = w;
    plen++;
  endtask

  // ---------------- reference model: architectural ISS ----------------
  task automatic iss();
    logic [31:0] pc, npc, ins, a, b, res, ii, is, ib, ij, ad;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        wr;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    for (int i = 0; i < 64; i++) m_dm[i] = '0;
    pc = '0;
    for (int step = 0; step < 2000; step++) begin
      ins = img[pc[7:2]];
      if (ins == HALT) break;
      f3 = ins[14:12];
      f7 = ins[31:25];
      a  = m_rf[ins[19:15]];
      b  = m_rf[ins[24:20]];
      ii = {{20{ins[31]}}, ins[31:20]};
      is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      npc = pc + 4;
      wr  = 1'b0;
      res = '0;
      case (ins[6:0])
        7'b0110011: begin
          wr = 1'b1;
          if (f7 == 7'h20 && f3 == 3'b000) res = a - b;
          else if (f7 != 7'h00) wr = 1'b0;
          else case (f3)
            3'd0: res = a + b;
            3'd1: res = a << b[4:0];
            3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd4: res = a ^ b;
            3'd5: res = a >> b[4:0];
            3'd6: res = a | b;
            3'd7: res = a & b;
            default: wr = 1'b0;
          endcase
        end
        7'b0010011: begin
          wr = 1'b1;
          case (f3)
            3'd0: res = a + ii;
            3'd2: res = ($signed(a) < $signed(ii)) ? 32'd1 : 32'd0;
            3'd4: res = a ^ ii;
            3'd6: res = a | ii;
            3'd7: res = a & ii;
            default: wr = 1'b0;
          endcase
        end
        7'b0000011: if (f3 == 3'd2) begin ad = a + ii; res = m_dm[ad[7:2]]; wr = 1'b1; end
        7'b0100011: if (f3 == 3'd2) begin ad = a + is; m_dm[ad[7:2]] = b; end
        7'b1100011: begin
          if (f3 == 3'd0 && a == b) npc = pc + ib;
          if (f3 == 3'd1 && a != b) npc = pc + ib;
        end
        7'b1101111: begin res = pc + 4; wr = 1'b1; npc = pc + ij; end
        default: ;
      endcase
      if (wr && ins[11:7] != 5'd0) m_rf[ins[11:7]] = res;
      pc = npc;
    end
  endtask

  // hold reset, load the image, release on a falling edge
  task automatic start();
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 64; i++) dut.imem[i] = img[i];
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic compare_all(input string tag);
    for (int r = 0; r < 32; r++) chk($sformatf("%s x%0d", tag, r), dut.rf[r], m_rf[r]);
    for (int d = 0; d < 64; d++) chk($sformatf("%s dmem[%0d]", tag, d), dut.dmem[d], m_dm[d]);
  endtask

  task automatic gen_random(input int len);
    int sel, rd, rs1, rs2, imm, off;
    clear();
    for (int k = 0; k < len; k++) begin
      sel = int'($urandom_range(0, 9));
      rd  = int'($urandom_range(0, 7));
      rs1 = int'($urandom_range(0, 7));
      rs2 = int'($urandom_range(0, 7));
      imm = int'($urandom_range(0, 4095)) - 2048;
      off = int'($urandom_range(1, len - k)) * 4;
      case (sel)
        0, 1: case ($urandom_range(0, 7))
          0: put(e_r(7'h00, 3'b000, rd, rs1, rs2));
          1: put(e_r(7'h20, 3'b000, rd, rs1, rs2));
          2: put(e_r(7'h00, 3'b001, rd, rs1, rs2));
          3: put(e_r(7'h00, 3'b010, rd, rs1, rs2));
          4: put(e_r(7'h00, 3'b100, rd, rs1, rs2));
          5: put(e_r(7'h00, 3'b101, rd, rs1, rs2));
          6: put(e_r(7'h00, 3'b110, rd, rs1, rs2));
          default: put(e_r(7'h00, 3'b111, rd, rs1, rs2));
        endcase
        2, 3: case ($urandom_range(0, 4))
          0: put(e_i(3'b000, rd, rs1, imm, 7'b0010011));
          1: put(e_i(3'b010, rd, rs1, imm, 7'b0010011));
          2: put(e_i(3'b100, rd, rs1, imm, 7'b0010011));
          3: put(e_i(3'b110, rd, rs1, imm, 7'b0010011));
          default: put(e_i(3'b111, rd, rs1, imm, 7'b0010011));
        endcase
        4: put(e_i(3'b010, rd, rs1, imm, 7'b0000011));
        5: put(e_s(rs2, rs1, imm));
        6: put(e_b($urandom_range(0, 1) != 0 ? 3'b001 : 3'b000, rs1, rs2, off));
        7: put(e_j(rd, off));
        8: case ($urandom_range(0, 4))
          0: put(e_r(7'h00, 3'b011, rd, rs1, rs2));          // sltu
          1: put(e_r(7'h20, 3'b101, rd, rs1, rs2));          // sra
          2: put(e_i(3'b000, rd, rs1, imm, 7'b0000011));     // lb
          3: put(e_i(3'b001, rd, rs1, 3, 7'b0010011));       // slli
          default: put(e_b(3'b100, rs1, rs2, 8));            // blt
        endcase
        default: put(addi(rd, rs1, imm));
      endcase
    end
  endtask

  initial begin
    rst = 1'b1;
    #2 rst = 1'b0;
    #1 chk("reset pc", dut.pc, 32'h0);
    chk("reset x1", dut.rf[1], 32'h0);

    // back-to-back forwarding, 4+4 cycles
    clear();
    put(addi(1, 0, 5)); put(addi(2, 0, 7));
    put(e_r(7'h00, 3'b000, 3, 1, 2)); put(e_r(7'h20, 3'b000, 4, 3, 1));
    start();
    cyc(7);
    chk("fwd x3 @7", dut.rf[3], 32'd12);
    chk("fwd x4 @7", dut.rf[4], 32'd0);
    cyc(1);
    chk("fwd x1", dut.rf[1], 32'd5);
    chk("fwd x2", dut.rf[2], 32'd7);
    chk("fwd x4 @8", dut.rf[4], 32'd7);

    // ALU and signed ops
    clear();
    put(addi(1, 0, -3)); put(e_r(7'h00, 3'b010, 2, 1, 0));
    put(e_r(7'h20, 3'b000, 3, 0, 1)); put(e_i(3'b100, 4, 1, -1, 7'b0010011));
    put(e_r(7'h00, 3'b101, 5, 1, 2));
    start();
    cyc(20);
    chk("alu x1", dut.rf[1], 32'hFFFF_FFFD);
    chk("alu slt", dut.rf[2], 32'd1);
    chk("alu sub", dut.rf[3], 32'd3);
    chk("alu xori", dut.rf[4], 32'd2);
    chk("alu srl", dut.rf[5], 32'h7FFF_FFFE);

    // load-use: one bubble
    clear();
    put(addi(3, 0, 12)); put(e_s(3, 0, 8));
    put(e_i(3'b010, 4, 0, 8, 7'b0000011)); put(e_r(7'h00, 3'b000, 5, 4, 4));
    start();
    cyc(8);
    chk("ldu x5 @8", dut.rf[5], 32'd0);
    cyc(1);
    chk("ldu x5 @9", dut.rf[5], 32'd24);
    chk("ldu x4", dut.rf[4], 32'd12);
    chk("ldu dmem2", dut.dmem[2], 32'd12);
    // asynchronous reset takes effect without a clock edge
    rst = 1'b0;
    #1;
    chk("async pc", dut.pc, 32'h0);
    chk("async x5", dut.rf[5], 32'h0);
    chk("async dmem2", dut.dmem[2], 32'h0);

    // branches taken / not taken
    clear();
    put(addi(1, 0, 1)); put(e_b(3'b000, 1, 1, 12));
    put(addi(6, 0, 9)); put(addi(7, 0, 9)); put(addi(8, 0, 4));
    put(e_b(3'b001, 1, 1, 8)); put(addi(9, 0, 2));
    start();
    cyc(8);
    chk("br x8 @8", dut.rf[8], 32'd0);
    cyc(1);
    chk("br x8 @9", dut.rf[8], 32'd4);
    cyc(1);
    chk("br x9 @10", dut.rf[9], 32'd0);
    cyc(1);
    chk("br x9 @11", dut.rf[9], 32'd2);
    chk("br x6", dut.rf[6], 32'd0);
    chk("br x7", dut.rf[7], 32'd0);

    // jal and x0
    clear();
    put(NOP); put(NOP); put(NOP); put(NOP);
    put(e_j(1, 8)); put(addi(2, 0, 1)); put(addi(0, 0, 5)); put(addi(3, 0, 6));
    start();
    cyc(20);
    chk("jal x1", dut.rf[1], 32'h14);
    chk("jal x2", dut.rf[2], 32'd0);
    chk("jal x0", dut.rf[0], 32'd0);
    chk("jal x3", dut.rf[3], 32'd6);

    // reset mid-run, then re-execute
    clear();
    put(addi(1, 0, 5)); put(addi(2, 0, 7));
    put(e_r(7'h00, 3'b000, 3, 1, 2)); put(e_r(7'h20, 3'b000, 4, 3, 1));
    start();
    cyc(6);
    chk("mid x2 pre", dut.rf[2], 32'd7);
    rst = 1'b0;
    cyc(3);
    chk("mid rst pc", dut.pc, 32'h0);
    for (int r = 0; r < 32; r++) chk($sformatf("mid rst x%0d", r), dut.rf[r], 32'h0);
    for (int d = 0; d < 64; d++) chk($sformatf("mid rst dmem[%0d]", d), dut.dmem[d], 32'h0);
    rst = 1'b1;
    cyc(8);
    chk("mid x1", dut.rf[1], 32'd5);
    chk("mid x2", dut.rf[2], 32'd7);
    chk("mid x3", dut.rf[3], 32'd12);
    chk("mid x4", dut.rf[4], 32'd7);

    // random programs against the reference model
    for (int t = 0; t < 6; t++) begin
      gen_random(30);
      iss();
      start();
      cyc(150);
      compare_all($sformatf("rnd%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
